// File: rtl/pulse_bit_decoder_pkg.sv
// Shared types for the serial LED pulse decoder: control-path edge strobes,
// decoder state encoding and the default tick counter width.
package pipeline_types;

    localparam int DEFAULT_TICK_W = 8;

    typedef struct packed {
        logic rising;
        logic falling;
    } control_path_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } decoder_state_t;

endpackage

// File: rtl/pulse_bit_decoder_tick_counter.sv
// Saturating tick counter with priority clear and ge-compares for the bit
// threshold (current count) and the timeout limit (value being loaded).
module pulse_tick_counter
    import pipeline_types::*;
#(
    parameter int TICK_W = DEFAULT_TICK_W,
    parameter int THRESH = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_clear,
    input  logic              i_enable,
    input  logic [TICK_W-1:0] i_limit,
    output logic              o_ge_thresh,
    output logic              o_ge_limit
);

    logic [TICK_W-1:0] count_q;
    logic [TICK_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && (count_q != '1)) begin
            count_d = count_q + TICK_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_ge_thresh = (count_q >= TICK_W'(THRESH));
    // Looking at the next value lets the timeout act in the cycle of the tick.
    assign o_ge_limit  = (count_d >= i_limit);

endmodule

// File: rtl/pulse_bit_decoder.sv
// Pulse-width bit decoder: classifies high pulses by tick count, assembles
// MSB-first words, flags latch gaps and errors. Macro PULSE_BIT_DECODER_STATS_EN adds o_word_count.
module pulse_bit_decoder
    import pipeline_types::*;
#(
    parameter int DATA_W         = 24,
    parameter int HIGH_THRESH    = 3,
    parameter int LATCH_TICKS    = 50,
    parameter int MAX_HIGH_TICKS = 10,
    parameter int TICK_W         = DEFAULT_TICK_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  control_path_t     i_control,
    input  logic              i_count_enable,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_latch,
    output logic              o_error
`ifdef PULSE_BIT_DECODER_STATS_EN
    ,
    output logic [15:0]       o_word_count
`endif
);

    localparam int BIT_W = $clog2(DATA_W + 1);

    decoder_state_t    state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d, word_next;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] data_d;
    logic              valid_d, latch_d, error_d;
    logic              cnt_clear, cnt_enable, ge_thresh, ge_limit;
    logic [TICK_W-1:0] cnt_limit;

    pulse_tick_counter #(
        .TICK_W (TICK_W),
        .THRESH (HIGH_THRESH)
    ) u_tick_counter (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (cnt_clear),
        .i_enable    (cnt_enable),
        .i_limit     (cnt_limit),
        .o_ge_thresh (ge_thresh),
        .o_ge_limit  (ge_limit)
    );

    assign word_next = {shift_q[DATA_W-2:0], ge_thresh};

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = o_data;
        valid_d    = o_valid && !i_ready;
        latch_d    = 1'b0;
        error_d    = 1'b0;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        cnt_limit  = TICK_W'(MAX_HIGH_TICKS);
        case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                if (i_control.rising) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (i_control.falling) begin
                    cnt_clear = 1'b1;
                    state_d   = LOW;
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        if (!o_valid || i_ready) begin
                            data_d  = word_next;
                            valid_d = 1'b1;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else begin
                        shift_d   = word_next;
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    cnt_enable = i_count_enable;
                    if (ge_limit) begin
                        error_d   = 1'b1;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        state_d   = IDLE;
                    end
                end
            end
            LOW: begin
                cnt_limit = TICK_W'(LATCH_TICKS);
                if (i_control.rising) begin
                    cnt_clear = 1'b1;
                    state_d   = HIGH;
                end else begin
                    cnt_enable = i_count_enable;
                    if (ge_limit) begin
                        latch_d   = 1'b1;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_latch   <= 1'b0;
            o_error   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            o_data    <= data_d;
            o_valid   <= valid_d;
            o_latch   <= latch_d;
            o_error   <= error_d;
        end
    end

`ifdef PULSE_BIT_DECODER_STATS_EN
    logic transfer;
    assign transfer = o_valid && i_ready;

    // A transfer landing on the latch pulse survives the clear as the first count.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_word_count <= '0;
        end else if (o_latch) begin
            o_word_count <= transfer ? 16'd1 : 16'd0;
        end else if (transfer) begin
            o_word_count <= o_word_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_bit_decoder.sv
// Directed bench for pulse_bit_decoder: expected words go into a queue as
// frames are sent and are compared when the DUT hands them over.
module tb_pulse_bit_decoder;
    import pipeline_types::*;

    localparam int DATA_W = 24;

    logic              i_clk = 1'b0;
    logic              i_reset;
    control_path_t     ctrl;
    logic              i_count_enable;
    logic [DATA_W-1:0] o_data;
    logic              o_valid;
    logic              i_ready;
    logic              o_latch;
    logic              o_error;
`ifdef PULSE_BIT_DECODER_STATS_EN
    logic [15:0]       o_word_count;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;
    int latch_cnt = 0;
    int err_cnt = 0;
    int valid_cycles = 0;
    int snap_v, snap_e, snap_l;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_w;

    always #5 i_clk = ~i_clk;

    pulse_bit_decoder dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_control      (ctrl),
        .i_count_enable (i_count_enable),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_latch        (o_latch),
        .o_error        (o_error)
`ifdef PULSE_BIT_DECODER_STATS_EN
        ,
        .o_word_count   (o_word_count)
`endif
    );

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, observe outputs mid-cycle, advance past the edge.
    task automatic step(input logic r, input logic f, input logic t);
        ctrl.rising    = r;
        ctrl.falling   = f;
        i_count_enable = t;
        @(negedge i_clk);
        if (o_valid) valid_cycles++;
        if (o_latch) latch_cnt++;
        if (o_error) err_cnt++;
        if (o_valid && i_ready) begin
            check(32'(exp_q.size() != 0), 32'd1, "sb_has_entry");
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                n_pop++;
                check(32'(o_data), 32'(exp_w), "word_data");
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_pulse(input int n, input logic rise_tick, input logic fall_tick);
        step(1'b1, 1'b0, rise_tick);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, fall_tick);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bit(input logic b);
        send_pulse(b ? 4 : 2, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w);
        for (int i = DATA_W - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    initial begin
        i_reset        = 1'b1;
        ctrl           = '0;
        i_count_enable = 1'b0;
        i_ready        = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check(32'(o_data), 32'd0, "rst_data");
        check(32'(o_valid), 32'd0, "rst_valid");
        check(32'(o_latch), 32'd0, "rst_latch");
        check(32'(o_error), 32'd0, "rst_error");
        i_reset = 1'b0;
        idle(2);

        // Basic frame with consumer ready
        snap_v = valid_cycles; snap_e = err_cnt;
        exp_q.push_back(24'hA5C33C);
        send_word(24'hA5C33C);
        idle(3);
        check(32'(valid_cycles - snap_v), 32'd1, "basic_valid_cycles");
        check(32'(err_cnt - snap_e), 32'd0, "basic_no_error");

        // Overrun: second word dropped while first is held
        i_ready = 1'b0;
        snap_e = err_cnt;
        exp_q.push_back(24'h13579B);
        send_word(24'h13579B);
        send_word(24'hFEDCBA);
        idle(2);
        check(32'(err_cnt - snap_e), 32'd1, "overrun_error_once");
        check(32'(o_data), 32'h13579B, "overrun_data_held");
        check(32'(o_valid), 32'd1, "overrun_valid_held");
        i_ready = 1'b1;
        idle(3);
        check(32'(o_valid), 32'd0, "overrun_drained");
        check(32'(exp_q.size()), 32'd0, "overrun_sb_empty");

        // Latch gap after a partial word
        snap_v = valid_cycles; snap_l = latch_cnt;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 1'b1);
        check(32'(latch_cnt - snap_l), 32'd0, "latch_not_early");
        idle(1);
        check(32'(latch_cnt - snap_l), 32'd1, "latch_at_tick50");
        idle(2);
        check(32'(latch_cnt - snap_l), 32'd1, "latch_single_pulse");
        check(32'(valid_cycles - snap_v), 32'd0, "latch_no_valid");
        exp_q.push_back(24'h123456);
        send_word(24'h123456);
        idle(3);

        // Malformed long high pulse
        snap_e = err_cnt;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
        check(32'(err_cnt - snap_e), 32'd0, "long_high_not_early");
        idle(1);
        check(32'(err_cnt - snap_e), 32'd1, "long_high_error");
        step(1'b0, 1'b1, 1'b0);
        idle(2);
        exp_q.push_back(24'h0F0F0F);
        send_word(24'h0F0F0F);
        idle(3);

        // Threshold boundary and coincident edge/tick cases
        for (int i = 0; i < 21; i++) send_bit(1'b1);
        send_pulse(3, 1'b0, 1'b0);
        send_pulse(2, 1'b1, 1'b0);
        exp_q.push_back(24'hFFFFFC);
        send_pulse(2, 1'b0, 1'b1);
        idle(3);

        // Asynchronous reset in the middle of bit 12 with a word held
        i_ready = 1'b0;
        send_word(24'h5A5A5A);
        for (int i = 0; i < 12; i++) send_bit(1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        ctrl = '0;
        i_count_enable = 1'b0;
        #2 i_reset = 1'b1;
        #1;
        check(32'(o_valid), 32'd0, "async_rst_valid");
        check(32'(o_data), 32'd0, "async_rst_data");
        @(posedge i_clk);
        #3 i_reset = 1'b0;
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        snap_l = latch_cnt;
        exp_q.push_back(24'h3C3CA5);
        send_word(24'h3C3CA5);
        idle(3);
        check(32'(latch_cnt - snap_l), 32'd0, "post_rst_no_latch");

        check(32'(exp_q.size()), 32'd0, "final_sb_empty");
        check(32'(n_pop), 32'd6, "final_words_popped");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pulse_bit_decoder.md
Name: pulse_bit_decoder

Overview:
- Downstream consumer of the clock-enable generator and the edge-detected control path.
- Measures each high pulse of the serial LED data line in enable ticks and classifies it as bit 0 or bit 1.
- Assembles DATA_W bits MSB-first into a word, presented on a valid/ready handshake.
- Detects the inter-frame latch gap (long low) and flags timing errors.

Parameters:
- DATA_W, 24: bits per assembled word (GRB pixel).
- HIGH_THRESH, 3: high-pulse tick count at or above which the bit is 1.
- LATCH_TICKS, 50: low ticks that constitute a latch/reset gap.
- MAX_HIGH_TICKS, 10: high ticks at which the pulse is declared malformed.
- TICK_W, 8: tick counter width; must hold max(LATCH_TICKS, MAX_HIGH_TICKS).

Ports:
- i_clk, input, 1: clock.
- i_reset, input, 1: reset, asynchronous, active-high.
- i_control, input, pipeline_types::control_path_t: uses .rising and .falling, each a one-cycle edge strobe.
- i_count_enable, input, 1: tick strobe from the clock-enable generator.
- o_data, output, DATA_W: assembled word.
- o_valid, output, 1: o_data holds an unconsumed word.
- i_ready, input, 1: consumer accepts the word.
- o_latch, output, 1: one-cycle pulse when a latch gap is detected.
- o_error, output, 1: one-cycle pulse on a malformed pulse or an overrun.

Behaviour:
- Reset: async, active-high.
  - State goes to IDLE; tick counter, bit counter and shift register are cleared.
  - o_data=0, o_valid=0, o_latch=0, o_error=0.
- States: IDLE, HIGH, LOW. All outputs are registered; edge-to-output latency is 1 clock.
- IDLE:
  - Ignores falling edges and ticks.
  - On rising: tick counter=0, go to HIGH.
- HIGH:
  - Each i_count_enable increments the tick counter.
  - On falling: bit = (tick counter before this cycle >= HIGH_THRESH). A tick arriving in the falling cycle is not counted.
  - The bit is shifted into the LSB (MSB-first word), bit counter increments, tick counter=0, go to LOW.
  - If the tick counter reaches MAX_HIGH_TICKS before falling: o_error pulses, partial word is discarded, bit counter=0, go to IDLE.
  - Rising edges are ignored.
- LOW:
  - Each tick increments the tick counter.
  - On rising: tick counter=0, go to HIGH. Rising takes priority over a same-cycle tick.
  - When the tick counter reaches LATCH_TICKS: o_latch pulses, partial word is discarded silently, bit counter=0, go to IDLE.
  - Falling edges are ignored.
- Word completion: on the falling edge that brings the bit counter to DATA_W:
  - If o_valid=0, or o_valid=1 with i_ready=1 in the same cycle: o_data is loaded with the full word, o_valid=1, and it stays 1 without a bubble.
  - If o_valid=1 and i_ready=0: the new word is dropped, the held word is unchanged, and o_error pulses (overrun).
  - The bit counter returns to 0 in every case.
- Handshake:
  - o_data is stable while o_valid=1.
  - Transfer occurs when o_valid and i_ready are both high; o_valid then clears next cycle unless a new word completes.
  - i_ready while o_valid=0 has no effect.
- Tick counter saturates at 2^TICK_W-1 and never wraps.
- Reset mid-word: everything is discarded; no o_valid or o_latch is generated.

Optional Feature:
- PULSE_BIT_DECODER_STATS_EN defined: adds output o_word_count (16 bits).
  - Increments on each accepted handshake transfer.
  - Wraps 0xFFFF to 0; reset value is 0.
  - Clears on o_latch, but not in the same cycle as a transfer: a transfer coinciding with o_latch leaves the count at 1.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package pipeline_types:
  - decoder_state_t enum (IDLE, HIGH, LOW).
  - TICK_W default constant.
  - Existing control_path_t (reused unchanged).
- One natural sub-module: pulse_tick_counter. It is a saturating TICK_W counter with clear (priority) and enable inputs, plus compare-ge outputs for the threshold and limit values.

Test Plan:
- 24 pulses, high 4 ticks for 1 and 2 ticks for 0, pattern 0xA5C33C; i_ready=1 → o_valid for exactly 1 cycle, o_data=0xA5C33C.
- Word completes with i_ready=0, then 24 more bits arrive → o_error pulses once, o_data stays at the first word; raising i_ready transfers the first word only.
- 5 bits, then line low for 50 ticks → o_latch pulses once at tick 50, no o_valid; the next 24 bits decode correctly from bit 0.
- High held for 10 ticks → o_error pulses at tick 10, state IDLE; a following valid frame decodes normally.
- Falling coincident with the 3rd tick (counter=2 before the cycle) → bit decoded as 0. Rising coincident with a tick in LOW → tick counter=0 in HIGH.
- i_reset asserted asynchronously mid-bit 12 → outputs are 0 immediately; after release, a full frame decodes with no stale bits.
